// File: rtl/uart_pkg.sv
// Shared UART types and widths for the transmit feeder and its FIFO.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer byte handshake plus transmitter launch handshake, seen from the feeder.
interface uart_tx_feeder_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] data_i;
   logic                   valid_i;
   logic                   ready_o;
   logic [UART_DATA_W-1:0] tx_data_o;
   logic                   tx_start_o;
   logic                   tx_done_i;

   modport master (
      output data_i, valid_i, tx_done_i,
      input  ready_o, tx_data_o, tx_start_o
   );

   modport slave (
      input  data_i, valid_i, tx_done_i,
      output ready_o, tx_data_o, tx_start_o
   );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, combinational head read; 1-cycle push-to-visible latency.
// Caller guarantees no push while full and no pop while empty.
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [UART_DATA_W-1:0] data_i,
   input  logic                   pop_i,
   output logic [UART_DATA_W-1:0] data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [UART_DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART transmitter.
// Push-to-start is 2 cycles; producer stalls on full, transmitter paced only by tx_done_i.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_i,
   uart_tx_feeder_if.slave        bus,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   overflow_o,
   output logic                   busy_o
);

   feeder_state_t          state_q;
   logic [UART_DATA_W-1:0] tx_data_q;
   logic                   tx_start_q;
   logic                   overflow_q;

   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   fifo_empty;
   logic [UART_DATA_W-1:0] head;

   assign push = bus.valid_i && !full;
   // Launch only from IDLE with the transmitter idle, so start never overlaps a frame.
   assign pop  = (state_q == IDLE) && !fifo_empty && bus.tx_done_i;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (bus.data_i),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (fifo_empty),
      .count_o (count_o)
   );

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (bus.valid_i && full) overflow_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  tx_data_q  <= head;
                  tx_start_q <= 1'b1;
                  state_q    <= START;
               end
            end
            START: begin
               tx_start_q <= 1'b0;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (bus.tx_done_i) state_q <= IDLE;
            end
            default: begin
               tx_start_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o    = !full;
   assign bus.tx_data_o  = tx_data_q;
   assign bus.tx_start_o = tx_start_q;
   assign empty_o        = fifo_empty;
   assign overflow_o     = overflow_q;
   assign busy_o         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte-stream buffer and launch sequencer directly upstream of the team's 8N1 UART transmitter. It accepts bytes from producer logic over a valid/ready handshake and stores them in an internal FIFO. It then issues one-cycle start pulses to the transmitter, one byte at a time, using the transmitter's done flag as the only flow control. Producers can therefore burst bytes at clock rate without tracking baud timing.

Parameters:
DEPTH, 16, FIFO capacity in bytes; power of two, at least 2.

Ports:
clk  input  1  system clock; all logic on posedge
rst_i  input  1  asynchronous, active-high reset
data_i  input  8  byte from producer
valid_i  input  1  producer has a byte on data_i
ready_o  output  1  FIFO can accept; equals !full
tx_data_o  output  8  byte to transmitter data input; registered
tx_start_o  output  1  one-cycle launch pulse to transmitter start input; registered
tx_done_i  input  1  transmitter idle/done flag (1 = idle)
count_o  output  $clog2(DEPTH)+1  bytes currently stored
empty_o  output  1  count_o == 0
overflow_o  output  1  sticky: valid_i seen while ready_o == 0
busy_o  output  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high (rst_i).
- Reset values: tx_start_o=0, tx_data_o=8'h00, count_o=0, empty_o=1, ready_o=1, overflow_o=0, busy_o=0, FSM=IDLE, read and write pointers=0.
- Reset mid-operation: a byte already accepted by the transmitter finishes on the line; the feeder does not abort it. After reset the FIFO is empty, so nothing more is launched.

Push rules:
- A push occurs on a clock edge where valid_i && ready_o; data_i is written at the write pointer.
- valid_i && !ready_o drops the byte, leaves the FIFO unchanged and sets overflow_o. overflow_o clears only on reset.

FSM:
- IDLE: if !empty && tx_done_i, pop the head byte into tx_data_o, set tx_start_o=1 and go to START.
- START: tx_start_o is high for exactly this cycle and the transmitter latches the byte. Next state is WAIT with tx_start_o=0.
- WAIT: tx_start_o=0. tx_done_i is low from the cycle after START. When tx_done_i==1, go to IDLE.
- tx_start_o is never asserted while tx_done_i==0. The transmitter's back-to-back path is deliberately unused, which costs one idle clock per byte.

Latency and throughput:
- A push into an empty FIFO with the transmitter idle gives tx_start_o high 2 cycles after the push edge (cycle N push, N+1 IDLE decides, N+2 START).
- Successive launches are spaced by the transmitter frame time plus 2 cycles.

Counting and pointers:
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count_o is incremented on push, decremented on pop, and unchanged on simultaneous push and pop.
- Push while full is impossible because ready_o=0. Pop while empty is impossible because the FSM is gated on !empty.
- tx_data_o holds its last value outside START.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - enum feeder_state_t {IDLE, START, WAIT}
- Sub-module byte_fifo: synchronous FIFO with parameter DEPTH, with push/pop/full/empty/count and the same async reset. The feeder is that FIFO plus the 3-state FSM and the overflow flag.

Test Plan:
- Bench instantiates the real transmitter with CLOCKS_PER_BAUD=4 and a line monitor.
1. Single byte: push 8'hA5 at cycle 10 -> tx_start_o high at cycle 12 only; line shows start bit 0, bits 1,0,1,0,0,1,0,1 (LSB first), stop bit 1; busy_o falls once done rises and the FIFO is empty.
2. Burst of 5 bytes 8'h01..8'h05 on consecutive cycles -> count_o peaks at 4 or 5; all five bytes appear on the line in order; no tx_start_o while tx_done_i==0.
3. Fill DEPTH=16 bytes with the transmitter busy -> ready_o=0 at count 16; a 17th valid sets overflow_o=1 and the byte is never transmitted; the other 16 are sent intact; pointer wrap is exercised.
4. Simultaneous push and pop at count 3 -> count_o stays 3; the popped byte is the oldest.
5. Assert rst_i asynchronously mid-frame with 4 bytes queued -> all outputs take reset values immediately; the current frame completes on the line; no further starts occur.
6. Hold tx_done_i low externally for 50 cycles with data queued -> tx_start_o stays 0; on release, start occurs 1 cycle after the IDLE decision.
